// File: rtl/decode_pkg.sv
// Shared decode constants: RV32I-subset opcodes, jump encodings, ALU codes
// and the halt-control state encoding used by the decode stage.
package decode_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BTYPE = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_HALT  = 7'b1111111;

    localparam logic [3:0] JUMP_NONE = 4'd0;
    localparam logic [3:0] JUMP_JAL  = 4'd2;
    localparam logic [3:0] JUMP_JALR = 4'd3;

    localparam logic [4:0] ALU_SUB = 5'b10000;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2
    } state_t;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational instruction decoder: control flags, sign-extended
// immediate and which source registers the instruction actually reads.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            reg_wrenable,
    output logic            mem_wrenable,
    output logic            mem_to_reg,
    output logic            alu_src,
    output logic            halt,
    output logic [3:0]      jump_type,
    output logic [4:0]      alu_op,
    output logic            uses_rs1,
    output logic            uses_rs2
);

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [31:0] imm32_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign rd       = instr[11:7];

    // Opcode-driven flag and immediate selection; unknown opcodes decode as NOP.
    always_comb begin
        imm32_s      = 32'd0;
        reg_wrenable = 1'b0;
        mem_wrenable = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src      = 1'b0;
        halt         = 1'b0;
        jump_type    = JUMP_NONE;
        alu_op       = 5'd0;
        uses_rs1     = 1'b0;
        uses_rs2     = 1'b0;
        case (opcode_s)
            OP_LOAD: begin
                imm32_s      = {{20{instr[31]}}, instr[31:20]};
                alu_src      = 1'b1;
                reg_wrenable = 1'b1;
                mem_to_reg   = 1'b1;
                uses_rs1     = 1'b1;
            end
            OP_ITYPE: begin
                imm32_s      = {{20{instr[31]}}, instr[31:20]};
                alu_src      = 1'b1;
                reg_wrenable = 1'b1;
                alu_op       = {2'b00, funct3_s};
                uses_rs1     = 1'b1;
            end
            OP_STORE: begin
                imm32_s      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                alu_src      = 1'b1;
                mem_wrenable = 1'b1;
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
            end
            OP_BTYPE: begin
                imm32_s   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                alu_op    = ALU_SUB;
                jump_type = {1'b1, funct3_s};
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            OP_JAL: begin
                imm32_s      = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                reg_wrenable = 1'b1;
                jump_type    = JUMP_JAL;
            end
            OP_JALR: begin
                imm32_s      = {{20{instr[31]}}, instr[31:20]};
                alu_src      = 1'b1;
                reg_wrenable = 1'b1;
                jump_type    = JUMP_JALR;
                uses_rs1     = 1'b1;
            end
            OP_RTYPE: begin
                alu_op       = {instr[30], instr[25], funct3_s};
                reg_wrenable = 1'b1;
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
            end
            OP_HALT: begin
                halt = 1'b1;
            end
            default: begin
                imm32_s = 32'd0;
            end
        endcase
    end

    assign imm = XLEN'($signed(imm32_s));

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: ID/EX pipeline register with valid/ready on both
// sides, load-use interlock, flush and a halt drain/lock state machine.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int STALL_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            reg_wrenable,
    output logic            mem_wrenable,
    output logic            mem_to_reg,
    output logic            alu_src,
    output logic            halt,
    output logic [3:0]      jump_type,
    output logic [4:0]      alu_op,
    output logic            halted
);

    logic [XLEN-1:0] dec_imm_s;
    logic [4:0]      dec_rs1_s, dec_rs2_s, dec_rd_s, dec_alu_op_s;
    logic            dec_rw_s, dec_mw_s, dec_m2r_s, dec_asrc_s, dec_halt_s;
    logic            dec_uses_rs1_s, dec_uses_rs2_s;
    logic [3:0]      dec_jt_s;

    logic [2:0]      lu_cnt_r;
    logic [4:0]      lu_rd_r;
    state_t          state_r, state_nxt_s;
    logic            run_s, hazard_s, accept_s, xfer_s;

    decode_comb #(.XLEN(XLEN)) u_decode_comb (
        .instr        (instr),
        .imm          (dec_imm_s),
        .rs1          (dec_rs1_s),
        .rs2          (dec_rs2_s),
        .rd           (dec_rd_s),
        .reg_wrenable (dec_rw_s),
        .mem_wrenable (dec_mw_s),
        .mem_to_reg   (dec_m2r_s),
        .alu_src      (dec_asrc_s),
        .halt         (dec_halt_s),
        .jump_type    (dec_jt_s),
        .alu_op       (dec_alu_op_s),
        .uses_rs1     (dec_uses_rs1_s),
        .uses_rs2     (dec_uses_rs2_s)
    );

    assign accept_s = in_valid && in_ready;
    assign xfer_s   = out_valid && out_ready;
    assign in_ready = run_s && !flush && !hazard_s && (!out_valid || out_ready);

    // Load-use hazard: a recently issued load (lu_cnt) or a load still held here.
    always_comb begin
        hazard_s = 1'b0;
        if ((lu_cnt_r != 3'd0) &&
            ((dec_uses_rs1_s && (dec_rs1_s == lu_rd_r)) ||
             (dec_uses_rs2_s && (dec_rs2_s == lu_rd_r)))) begin
            hazard_s = 1'b1;
        end else if (out_valid && mem_to_reg && (rd != 5'd0) &&
                     ((dec_uses_rs1_s && (dec_rs1_s == rd)) ||
                      (dec_uses_rs2_s && (dec_rs2_s == rd)))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end

    // ID/EX register; flush wins, and a same-cycle transfer plus accept overwrites.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            imm          <= '0;
            rs1          <= 5'd0;
            rs2          <= 5'd0;
            rd           <= 5'd0;
            reg_wrenable <= 1'b0;
            mem_wrenable <= 1'b0;
            mem_to_reg   <= 1'b0;
            alu_src      <= 1'b0;
            halt         <= 1'b0;
            jump_type    <= 4'd0;
            alu_op       <= 5'd0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept_s) begin
            out_valid    <= 1'b1;
            imm          <= dec_imm_s;
            rs1          <= dec_rs1_s;
            rs2          <= dec_rs2_s;
            rd           <= dec_rd_s;
            reg_wrenable <= dec_rw_s;
            mem_wrenable <= dec_mw_s;
            mem_to_reg   <= dec_m2r_s;
            alu_src      <= dec_asrc_s;
            halt         <= dec_halt_s;
            jump_type    <= dec_jt_s;
            alu_op       <= dec_alu_op_s;
        end else if (xfer_s) begin
            out_valid <= 1'b0;
        end
    end

    // Load-use tracker, armed when a load with a real destination leaves to execute.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_cnt_r <= 3'd0;
            lu_rd_r  <= 5'd0;
        end else if (flush) begin
            lu_cnt_r <= 3'd0;
        end else if (xfer_s && mem_to_reg && (rd != 5'd0)) begin
            lu_cnt_r <= 3'(STALL_CYCLES);
            lu_rd_r  <= rd;
        end else if (lu_cnt_r != 3'd0) begin
            lu_cnt_r <= lu_cnt_r - 3'd1;
        end
    end

    // Halt FSM state register; halted mirrors the locked state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RUN;
            halted  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            halted  <= (state_nxt_s == HALTED);
        end
    end

    // Halt FSM next state; only reset leaves HALTED.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN: begin
                if (accept_s && dec_halt_s) begin
                    state_nxt_s = HALT_PEND;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            HALT_PEND: begin
                if (flush) begin
                    state_nxt_s = RUN;
                end else if (xfer_s && halt) begin
                    state_nxt_s = HALTED;
                end else begin
                    state_nxt_s = HALT_PEND;
                end
            end
            HALTED: begin
                state_nxt_s = HALTED;
            end
            default: begin
                state_nxt_s = RUN;
            end
        endcase
    end

    // Halt FSM outputs.
    always_comb begin
        run_s = 1'b0;
        case (state_r)
            RUN:     run_s = 1'b1;
            default: run_s = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized and directed bench for decode_stage, checked every cycle against
// a reference model built from the instruction-set decode rules.
module tb_decode_stage;

    localparam int XLEN  = 64;
    localparam int STALL = 2;

    localparam logic [31:0] I_ADDI1 = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] I_ADD2  = 32'h00108133;  // add x2,x1,x1
    localparam logic [31:0] I_LW3   = 32'h00002183;  // lw x3,0(x0)
    localparam logic [31:0] I_ADD4  = 32'h00018233;  // add x4,x3,x0
    localparam logic [31:0] I_ADDI5 = 32'h00100293;  // addi x5,x0,1
    localparam logic [31:0] I_BEQ   = 32'hFE000CE3;  // beq x0,x0,-8
    localparam logic [31:0] I_BGEU  = 32'hFE007CE3;  // bgeu x0,x0,-8
    localparam logic [31:0] I_JAL   = 32'hFFDFF0EF;  // jal x1,-4
    localparam logic [31:0] I_HALT  = 32'h0000007F;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     instr = 32'd0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1, rs2, rd, alu_op;
    logic            reg_wrenable, mem_wrenable, mem_to_reg, alu_src, halt, halted;
    logic [3:0]      jump_type;

    decode_stage #(.XLEN(XLEN), .STALL_CYCLES(STALL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd),
        .reg_wrenable(reg_wrenable), .mem_wrenable(mem_wrenable),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .halt(halt),
        .jump_type(jump_type), .alu_op(alu_op), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mw, m2r, asrc, hlt;
        logic [3:0]  jt;
        logic [4:0]  aop;
        logic        u1, u2;
    } dec_t;

    int   total = 0;
    int   bad   = 0;
    logic last_rdy;

    // reference state: held entry, outstanding load, mode 0=run 1=halt pending 2=halted
    dec_t       held_m;
    logic       ov_m;
    int         lu_cnt_m;
    logic [4:0] lu_rd_m;
    int         mode_m;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t   d;
        longint sx, top;
        sx  = longint'($signed(ins));
        top = sx >>> 31;
        d = '0;
        d.rs1 = ins[19:15];
        d.rs2 = ins[24:20];
        d.rd  = ins[11:7];
        case (ins[6:0])
            7'b0000011: begin d.imm = sx >>> 20; d.asrc = 1'b1; d.rw = 1'b1; d.m2r = 1'b1; d.u1 = 1'b1; end
            7'b0010011: begin d.imm = sx >>> 20; d.asrc = 1'b1; d.rw = 1'b1; d.aop = {2'b00, ins[14:12]}; d.u1 = 1'b1; end
            7'b0100011: begin
                d.imm = (sx >>> 25) * 32 + int'(ins[11:7]);
                d.asrc = 1'b1; d.mw = 1'b1; d.u1 = 1'b1; d.u2 = 1'b1;
            end
            7'b1100011: begin
                d.imm = top * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
                d.aop = 5'd16; d.jt = {1'b1, ins[14:12]}; d.u1 = 1'b1; d.u2 = 1'b1;
            end
            7'b1101111: begin
                d.imm = top * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
                d.rw = 1'b1; d.jt = 4'd2;
            end
            7'b1100111: begin d.imm = sx >>> 20; d.asrc = 1'b1; d.rw = 1'b1; d.jt = 4'd3; d.u1 = 1'b1; end
            7'b0110011: begin d.aop = {ins[30], ins[25], ins[14:12]}; d.rw = 1'b1; d.u1 = 1'b1; d.u2 = 1'b1; end
            7'b1111111: d.hlt = 1'b1;
            default:    d.hlt = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  op;
        case ($urandom_range(0, 7))
            0: op = 7'b0000011;
            1: op = 7'b0010011;
            2: op = 7'b0100011;
            3: op = 7'b1100011;
            4: op = 7'b1101111;
            5: op = 7'b1100111;
            6: op = 7'b0110011;
            default: op = 7'b0001111;
        endcase
        ins = $urandom;
        ins[6:0]   = op;
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        return ins;
    endfunction

    task automatic model_reset();
        held_m = '0; ov_m = 1'b0; lu_cnt_m = 0; lu_rd_m = 5'd0; mode_m = 0;
    endtask

    // one clock: drive inputs, check DUT mid-cycle against the model, advance the model
    task automatic tick(input logic v, input logic [31:0] ins, input logic fl, input logic ordy);
        dec_t d;
        logic haz, rdy_m, acc, xfer;
        in_valid = v; instr = ins; flush = fl; out_ready = ordy;
        d = ref_decode(ins);
        haz = ((lu_cnt_m > 0) && ((d.u1 && d.rs1 == lu_rd_m) || (d.u2 && d.rs2 == lu_rd_m))) ||
              (ov_m && held_m.m2r && held_m.rd != 5'd0 &&
               ((d.u1 && d.rs1 == held_m.rd) || (d.u2 && d.rs2 == held_m.rd)));
        rdy_m = (mode_m == 0) && !fl && !haz && (!ov_m || ordy);
        #3;
        last_rdy = in_ready;
        check_val("in_ready", 64'(in_ready), 64'(rdy_m));
        check_val("out_valid", 64'(out_valid), 64'(ov_m));
        check_val("halted", 64'(halted), 64'(mode_m == 2));
        if (ov_m) begin
            check_val("imm", imm, held_m.imm);
            check_val("regs", 64'({rs1, rs2, rd}), 64'({held_m.rs1, held_m.rs2, held_m.rd}));
            check_val("flags", 64'({reg_wrenable, mem_wrenable, mem_to_reg, alu_src, halt}),
                      64'({held_m.rw, held_m.mw, held_m.m2r, held_m.asrc, held_m.hlt}));
            check_val("jump_type", 64'(jump_type), 64'(held_m.jt));
            check_val("alu_op", 64'(alu_op), 64'(held_m.aop));
        end
        acc  = v && rdy_m;
        xfer = ov_m && ordy;
        if (fl) begin
            ov_m = 1'b0; lu_cnt_m = 0;
            if (mode_m == 1) mode_m = 0;
        end else begin
            if (xfer && held_m.m2r && held_m.rd != 5'd0) begin
                lu_rd_m = held_m.rd; lu_cnt_m = STALL;
            end else if (lu_cnt_m > 0) begin
                lu_cnt_m--;
            end
            if (mode_m == 1 && xfer && held_m.hlt) mode_m = 2;
            if (acc && d.hlt) mode_m = 1;
            if (acc) begin
                held_m = d; ov_m = 1'b1;
            end else if (xfer) begin
                ov_m = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int stalls;
        model_reset();
        @(posedge clk);
        #1;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_imm", imm, 64'd0);
        check_val("rst_halted", 64'(halted), 64'd0);
        rst = 1'b0;

        // back-to-back independent stream
        tick(1'b1, I_ADDI1, 1'b0, 1'b1);
        check_val("b2b_first", 64'(last_rdy), 64'd1);
        tick(1'b1, I_ADD2, 1'b0, 1'b1);
        check_val("b2b_second", 64'(last_rdy), 64'd1);
        check_val("add_rd", 64'(rd), 64'd2);
        check_val("add_aluop", 64'(alu_op), 64'd0);
        tick(1'b0, 32'd0, 1'b0, 1'b1);

        // load-use interlock
        tick(1'b1, I_LW3, 1'b0, 1'b1);
        tick(1'b1, I_ADD4, 1'b0, 1'b1);
        check_val("lu_held_stall", 64'(last_rdy), 64'd0);
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, I_ADD4, 1'b0, 1'b1);
            if (last_rdy) break;
            stalls++;
        end
        check_val("lu_stall_cycles", 64'(stalls), 64'(STALL));
        tick(1'b0, 32'd0, 1'b0, 1'b1);
        tick(1'b1, I_LW3, 1'b0, 1'b1);
        tick(1'b1, I_ADDI5, 1'b0, 1'b1);
        check_val("lu_independent", 64'(last_rdy), 64'd1);
        for (int i = 0; i < 3; i++) tick(1'b0, 32'd0, 1'b0, 1'b1);

        // branches
        tick(1'b1, I_BEQ, 1'b0, 1'b1);
        check_val("beq_imm", imm, 64'hFFFF_FFFF_FFFF_FFF8);
        check_val("beq_jt", 64'(jump_type), 64'd8);
        check_val("beq_aluop", 64'(alu_op), 64'd16);
        tick(1'b1, I_BGEU, 1'b0, 1'b1);
        check_val("bgeu_jt", 64'(jump_type), 64'd15);
        tick(1'b0, 32'd0, 1'b0, 1'b1);

        // backpressure hold then release
        tick(1'b1, I_ADDI1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, I_ADD2, 1'b0, 1'b0);
            check_val("hold_rdy", 64'(last_rdy), 64'd0);
            check_val("hold_imm", imm, 64'd5);
        end
        tick(1'b1, I_ADD2, 1'b0, 1'b1);
        check_val("release_rdy", 64'(last_rdy), 64'd1);
        check_val("release_rd", 64'(rd), 64'd2);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            tick(($urandom_range(0, 3) != 0), rand_instr(), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 7));
        end

        // reset in the middle of a load-use stall
        for (int i = 0; i < 4; i++) tick(1'b0, 32'd0, 1'b0, 1'b1);
        tick(1'b1, I_LW3, 1'b0, 1'b1);
        tick(1'b1, I_ADD4, 1'b0, 1'b1);
        tick(1'b1, I_ADD4, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        check_val("mrst_out_valid", 64'(out_valid), 64'd0);
        check_val("mrst_imm", imm, 64'd0);
        check_val("mrst_regs", 64'({rs1, rs2, rd}), 64'd0);
        check_val("mrst_flags", 64'({reg_wrenable, mem_wrenable, mem_to_reg, alu_src, halt}), 64'd0);
        check_val("mrst_ctl", 64'({jump_type, alu_op, halted}), 64'd0);
        check_val("mrst_in_ready", 64'(in_ready), 64'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1'b1, I_JAL, 1'b0, 1'b1);
        check_val("jal_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check_val("jal_jt", 64'(jump_type), 64'd2);
        tick(1'b0, 32'd0, 1'b0, 1'b1);

        // halt, flushed away, then halt for real
        tick(1'b1, I_HALT, 1'b0, 1'b0);
        check_val("halt_accept", 64'(last_rdy), 64'd1);
        tick(1'b0, 32'd0, 1'b1, 1'b0);
        tick(1'b0, 32'd0, 1'b0, 1'b0);
        check_val("halt_flush_halted", 64'(halted), 64'd0);
        check_val("halt_flush_run", 64'(last_rdy), 64'd1);
        tick(1'b1, I_HALT, 1'b0, 1'b0);
        tick(1'b0, 32'd0, 1'b0, 1'b1);
        tick(1'b0, 32'd0, 1'b0, 1'b1);
        check_val("halted_set", 64'(halted), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, I_ADDI1, 1'b0, 1'b1);
            check_val("halted_lock", 64'(last_rdy), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
